ocra1_rx: RTL
=============

Name: ocra1_rx

Overview:
- Receive-side counterpart of the OCRA1 GPA serial link.
- Oversamples the four-channel SPI bus (SCLK, SYNCn, LDACn, four data lines) on the system clock and deserialises one 24-bit word per channel per frame.
- Mirrors the GPA DAC input/holding register pair: a shadow register written at end of frame, and an output register loaded on LDACn falling.
- Used as a loopback checker in simulation and on-FPGA self-test of the gradient serialiser.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser (minimum 2).
- CNT_W, 16, width of the frame and error counters.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- oc1_clk_i  in  1  SPI clock from serialiser.
- oc1_syncn_i  in  1  frame select, active low.
- oc1_ldacn_i  in  1  DAC load strobe, active low.
- oc1_sdox_i, oc1_sdoy_i, oc1_sdoz_i, oc1_sdoz2_i  in  1 each  serial data, MSB first.
- shadowx_o, shadowy_o, shadowz_o, shadowz2_o  out  24 each  last complete received words.
- dacx_o, dacy_o, dacz_o, dacz2_o  out  24 each  words transferred by LDACn.
- word_valid_o  out  1  one-cycle pulse when the shadow registers update.
- ldac_o  out  1  one-cycle pulse when the dac registers update.
- frame_err_o  out  1  one-cycle pulse on a frame whose bit count is not 24.
- busy_o  out  1  high while a frame is open (synchronised SYNCn low).
- frame_cnt_o  out  CNT_W  good frames received.
- err_cnt_o  out  CNT_W  bad frames received.

Behaviour:
- **Reset:** all outputs, counters, shift registers and synchronisers are cleared to 0, except the SYNCn and LDACn synchronisers, which reset to 1. Reset is asynchronous assert; deassertion is sampled on clk.
- **Synchronisers:** all 7 inputs pass through SYNC_STAGES flip-flops. One extra registered copy of SCLK, SYNCn and LDACn is kept for edge detection.
- **Timing requirement:** SCLK high and low phases must each be at least 2 clk periods. Faster SCLK is out of scope and is not detected.
- **Sampling:** on a synchronised SCLK falling edge while synchronised SYNCn is low:
  - each channel shift register shifts left and takes its data bit into bit 0;
  - the 6-bit bit counter increments, saturating at 63.
- SCLK edges while SYNCn is high are ignored.
- **FSM states:**
  - IDLE: SYNCn high.
  - SHIFT: SYNCn low; busy_o=1.
  - IDLE->SHIFT on SYNCn falling edge; the bit counter clears in that cycle.
  - An SCLK falling edge in the same cycle as the SYNCn falling edge is sampled as bit 1 (the counter loads 1).
  - SHIFT->IDLE on SYNCn rising edge:
    - if count==24: shadow regs <= shift regs, word_valid_o=1, frame_cnt_o increments;
    - otherwise: shadow regs are unchanged, frame_err_o=1, err_cnt_o increments.
- **Latency:** word_valid_o is asserted SYNC_STAGES+1 clk after the SYNCn rising edge at the pin.
- **LDACn falling edge:** dac regs <= shadow regs and ldac_o=1, in any state.
  - If it coincides with a good-frame shadow update, the dac regs take the newly received words. This is a bypass, not the old shadow values.
  - LDACn low while SYNCn is low is legal and transfers the previous shadow values.
- **Counters:** both wrap from 2^CNT_W-1 to 0 with no flag.
- **Reset mid-frame:** the partial frame is discarded, no pulse is issued, and the FSM is in IDLE after reset.
- **Zero-length frame** (SYNCn low then high with no SCLK): it is a bad frame and err_cnt_o increments.

Test Plan:
1. Reset, then one frame with X=0x123456, Y=0xABCDEF, Z=0x000001, Z2=0x800000 and 24 SCLK falling edges -> word_valid_o one pulse, shadow regs equal those values, frame_cnt_o=1, dac regs still 0.
2. LDACn pulse low 4 clk after test 1 -> ldac_o one pulse; dacx_o=0x123456, dacz2_o=0x800000.
3. Frame with 23 bits, then a frame with 25 bits -> two frame_err_o pulses, err_cnt_o=2, shadow regs unchanged from test 1.
4. SYNCn rising and LDACn falling aligned at the pins on a good frame with X=0x00FFFF -> word_valid_o and ldac_o in the same cycle, dacx_o=0x00FFFF.
5. rstn asserted after 12 bits of a frame, then released and a clean 0x5A5A5A frame sent -> no pulse during the aborted frame; after the clean frame, shadowx_o=0x5A5A5A and frame_cnt_o=1.
6. CNT_W=4 with 17 good frames -> frame_cnt_o=1. SCLK toggling while SYNCn is high -> no shift and no count change.

Source files
------------

// File: rtl/ocra1_rx_if.sv
// OCRA1 receive-side bundle: raw serial pins in, deserialised words and status out.
interface ocra1_rx_if #(
  parameter int unsigned CNT_W = 16
);
  logic              oc1_clk_i;
  logic              oc1_syncn_i;
  logic              oc1_ldacn_i;
  logic              oc1_sdox_i;
  logic              oc1_sdoy_i;
  logic              oc1_sdoz_i;
  logic              oc1_sdoz2_i;
  logic [23:0]       shadowx_o;
  logic [23:0]       shadowy_o;
  logic [23:0]       shadowz_o;
  logic [23:0]       shadowz2_o;
  logic [23:0]       dacx_o;
  logic [23:0]       dacy_o;
  logic [23:0]       dacz_o;
  logic [23:0]       dacz2_o;
  logic              word_valid_o;
  logic              ldac_o;
  logic              frame_err_o;
  logic              busy_o;
  logic [CNT_W-1:0]  frame_cnt_o;
  logic [CNT_W-1:0]  err_cnt_o;

  // Serialiser side: drives the link, observes the receiver.
  modport master (
    output oc1_clk_i, oc1_syncn_i, oc1_ldacn_i,
    output oc1_sdox_i, oc1_sdoy_i, oc1_sdoz_i, oc1_sdoz2_i,
    input  shadowx_o, shadowy_o, shadowz_o, shadowz2_o,
    input  dacx_o, dacy_o, dacz_o, dacz2_o,
    input  word_valid_o, ldac_o, frame_err_o, busy_o, frame_cnt_o, err_cnt_o
  );

  // Receiver side.
  modport slave (
    input  oc1_clk_i, oc1_syncn_i, oc1_ldacn_i,
    input  oc1_sdox_i, oc1_sdoy_i, oc1_sdoz_i, oc1_sdoz2_i,
    output shadowx_o, shadowy_o, shadowz_o, shadowz2_o,
    output dacx_o, dacy_o, dacz_o, dacz2_o,
    output word_valid_o, ldac_o, frame_err_o, busy_o, frame_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/ocra1_rx.sv
// OCRA1 GPA link receiver: oversamples the 4-channel SPI bus and mirrors the
// DAC input (shadow) / output (dac) register pair.
module ocra1_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic       clk,
  input logic       rstn,
  ocra1_rx_if.slave bus
);
  localparam int unsigned WORD_W = 24;
  localparam int unsigned BCNT_W = 6;
  localparam int unsigned NPIN   = 7;
  localparam int unsigned NCH    = 4;
  // Pin order {sdoz2, sdoz, sdoy, sdox, ldacn, syncn, sclk}; active-low strobes idle high.
  localparam logic [NPIN-1:0]   SYNC_RST  = 7'b000_0110;
  localparam logic [BCNT_W-1:0] BCNT_MAX  = 6'd63;
  localparam logic [BCNT_W-1:0] BCNT_WORD = 6'd24;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [NPIN-1:0]                   pins_c;
  logic [SYNC_STAGES-1:0][NPIN-1:0]  sync_q, sync_d;
  logic [2:0]                        prev_q, prev_d;
  state_t                            state_q, state_d;
  logic [BCNT_W-1:0]                 bcnt_q, bcnt_d;
  logic [NCH-1:0][WORD_W-1:0]        shift_q, shift_d;
  logic [NCH-1:0][WORD_W-1:0]        shadow_q, shadow_d;
  logic [NCH-1:0][WORD_W-1:0]        dac_q, dac_d;
  logic                              word_valid_q, word_valid_d;
  logic                              ldac_q, ldac_d;
  logic                              frame_err_q, frame_err_d;
  logic                              busy_q, busy_d;
  logic [CNT_W-1:0]                  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]                  err_cnt_q, err_cnt_d;

  logic [NPIN-1:0] sync_s_c;
  logic            sclk_s_c, syncn_s_c, ldacn_s_c;
  logic [NCH-1:0]  data_s_c;
  logic            sclk_fall_c, syncn_fall_c, syncn_rise_c, ldac_fall_c, sample_c;

  assign pins_c = {bus.oc1_sdoz2_i, bus.oc1_sdoz_i, bus.oc1_sdoy_i, bus.oc1_sdox_i,
                   bus.oc1_ldacn_i, bus.oc1_syncn_i, bus.oc1_clk_i};

  assign sync_s_c     = sync_q[SYNC_STAGES-1];
  assign sclk_s_c     = sync_s_c[0];
  assign syncn_s_c    = sync_s_c[1];
  assign ldacn_s_c    = sync_s_c[2];
  assign data_s_c     = sync_s_c[6:3];
  assign sclk_fall_c  = prev_q[0] & ~sclk_s_c;
  assign syncn_fall_c = prev_q[1] & ~syncn_s_c;
  assign syncn_rise_c = ~prev_q[1] & syncn_s_c;
  assign ldac_fall_c  = prev_q[2] & ~ldacn_s_c;
  assign sample_c     = sclk_fall_c & ~syncn_s_c;

  // Synchroniser chain plus one delayed copy of the control lines for edge detection.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pins_c;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_s_c[2:0];
  end

  // Frame FSM, deserialiser, shadow/dac transfer and counters.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    shadow_d     = shadow_q;
    dac_d        = dac_q;
    word_valid_d = 1'b0;
    ldac_d       = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (sample_c) begin
      for (int c = 0; c < NCH; c++) begin
        shift_d[c] = {shift_q[c][WORD_W-2:0], data_s_c[c]};
      end
    end

    case (state_q)
      IDLE: begin
        if (syncn_fall_c) begin
          state_d = SHIFT;
          bcnt_d  = sample_c ? BCNT_W'(1) : BCNT_W'(0);
        end
      end
      SHIFT: begin
        if (syncn_rise_c) begin
          state_d = IDLE;
          if (bcnt_q == BCNT_WORD) begin
            shadow_d     = shift_q;
            word_valid_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          end else begin
            frame_err_d = 1'b1;
            err_cnt_d   = err_cnt_q + CNT_W'(1);
          end
        end else if (sample_c && (bcnt_q != BCNT_MAX)) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // shadow_d already holds a same-cycle frame update, giving the bypass.
    if (ldac_fall_c) begin
      dac_d  = shadow_d;
      ldac_d = 1'b1;
    end

    busy_d = (state_d == SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q       <= {SYNC_STAGES{SYNC_RST}};
      prev_q       <= 3'b110;
      state_q      <= IDLE;
      bcnt_q       <= '0;
      shift_q      <= '0;
      shadow_q     <= '0;
      dac_q        <= '0;
      word_valid_q <= 1'b0;
      ldac_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      shadow_q     <= shadow_d;
      dac_q        <= dac_d;
      word_valid_q <= word_valid_d;
      ldac_q       <= ldac_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.shadowx_o    = shadow_q[0];
  assign bus.shadowy_o    = shadow_q[1];
  assign bus.shadowz_o    = shadow_q[2];
  assign bus.shadowz2_o   = shadow_q[3];
  assign bus.dacx_o       = dac_q[0];
  assign bus.dacy_o       = dac_q[1];
  assign bus.dacz_o       = dac_q[2];
  assign bus.dacz2_o      = dac_q[3];
  assign bus.word_valid_o = word_valid_q;
  assign bus.ldac_o       = ldac_q;
  assign bus.frame_err_o  = frame_err_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_cnt_o  = frame_cnt_q;
  assign bus.err_cnt_o    = err_cnt_q;
endmodule
